// File: rtl/tl_scoreboard_mc.sv
// tl_scoreboard_mc: reference-memory scoreboard for NUM_CH TileLink L1 agents.
// Completed Get/PutFull/PutPartial transactions are folded into a shadow model.
// Every Get is checked against that model. Errors, counts and a watchdog flag
// are reported on registered outputs.
//
// Handshake: txn_valid[ch] is a one-cycle completion strobe with no ready.
// The scoreboard never back-pressures. A strobe seen outside RUN is rejected
// with code 11 and is not counted.
module tl_scoreboard_mc #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 1024,
  parameter int TIMEOUT   = 10000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             txn_valid,
  input  logic [2*NUM_CH-1:0]           txn_type,
  input  logic [ADDR_W*NUM_CH-1:0]      txn_addr,
  input  logic [DATA_W*NUM_CH-1:0]      txn_wdata,
  input  logic [DATA_W/8*NUM_CH-1:0]    txn_mask,
  input  logic [DATA_W*NUM_CH-1:0]      txn_rdata,
  input  logic                          test_done,
  output logic                          init_done,
  output logic                          all_pass,
  output logic                          err_valid,
  output logic [1:0]                    err_code,
  output logic [$clog2(NUM_CH)-1:0]     err_ch,
  output logic [ADDR_W-1:0]             err_addr,
  output logic [15:0]                   err_count,
  output logic [31:0]                   txn_count,
  output logic                          timeout
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    clr_ptr_q;
  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];
  logic [WD_W-1:0]     wd_q;

  logic [1:0]          typ      [NUM_CH];
  logic [ADDR_W-1:0]   addr     [NUM_CH];
  logic [ADDR_W-1:0]   idx_full [NUM_CH];
  logic [IDX_W-1:0]    idx      [NUM_CH];
  logic                in_rng   [NUM_CH];
  logic                is_put   [NUM_CH];
  logic [BYTES-1:0]    wmask    [NUM_CH];
  logic [DATA_W-1:0]   cur      [NUM_CH];
  logic [DATA_W-1:0]   nxt      [NUM_CH];
  logic                ch_err   [NUM_CH];
  logic [1:0]          ch_code  [NUM_CH];
  logic                ch_cnt   [NUM_CH];

  logic                any_err;
  logic [CH_W-1:0]     sel_ch;
  logic [1:0]          sel_code;
  logic [ADDR_W-1:0]   sel_addr;
  logic [16:0]         n_err;
  logic [31:0]         n_txn;
  logic [16:0]         err_sum;

  // Byte-lane merge: lanes with mask set take the new data.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [BYTES-1:0]  m);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BYTES; b++) begin
      if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Decode each channel, forward lower-channel Puts, and classify errors.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      typ[i]      = txn_type[2*i +: 2];
      addr[i]     = txn_addr[ADDR_W*i +: ADDR_W];
      idx_full[i] = addr[i] >> OFF;
      in_rng[i]   = idx_full[i] < ADDR_W'(MEM_DEPTH);
      idx[i]      = idx_full[i][IDX_W-1:0];
      is_put[i]   = (state_q == ST_RUN) && txn_valid[i] && in_rng[i] &&
                    (typ[i] == 2'b01 || typ[i] == 2'b10);
      wmask[i]    = (typ[i] == 2'b01) ? {BYTES{1'b1}} : txn_mask[BYTES*i +: BYTES];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      cur[i] = mem_q[idx[i]];
      for (int j = 0; j < i; j++) begin
        if (is_put[j] && idx[j] == idx[i])
          cur[i] = merge(cur[i], txn_wdata[DATA_W*j +: DATA_W], wmask[j]);
      end
      nxt[i]     = merge(cur[i], txn_wdata[DATA_W*i +: DATA_W], wmask[i]);
      ch_err[i]  = 1'b0;
      ch_code[i] = 2'b00;
      ch_cnt[i]  = 1'b0;
      if (txn_valid[i]) begin
        if (state_q != ST_RUN) begin
          ch_err[i]  = 1'b1;
          ch_code[i] = 2'b11;
        end else begin
          ch_cnt[i] = 1'b1;
          if (typ[i] == 2'b11) begin
            ch_err[i]  = 1'b1;
            ch_code[i] = 2'b01;
          end else if (!in_rng[i]) begin
            ch_err[i]  = 1'b1;
            ch_code[i] = 2'b10;
          end else if (typ[i] == 2'b00 &&
                       txn_rdata[DATA_W*i +: DATA_W] !== cur[i]) begin
            ch_err[i]  = 1'b1;
            ch_code[i] = 2'b00;
          end
        end
      end
    end
  end

  // Reduce per-channel results: error/txn totals and lowest erroring channel.
  always_comb begin
    any_err  = 1'b0;
    sel_ch   = '0;
    sel_code = 2'b00;
    sel_addr = '0;
    n_err    = '0;
    n_txn    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      n_err = n_err + 17'(ch_err[i]);
      n_txn = n_txn + 32'(ch_cnt[i]);
      if (ch_err[i]) begin
        any_err  = 1'b1;
        sel_ch   = CH_W'(i);
        sel_code = ch_code[i];
        sel_addr = addr[i];
      end
    end
    err_sum = {1'b0, err_count} + n_err;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // FSM next state: INIT sweeps the model, RUN until test_done, DONE is terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (clr_ptr_q == IDX_W'(MEM_DEPTH - 1)) state_d = ST_RUN;
      ST_RUN:  if (test_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_INIT;
    endcase
  end

  // Clear pointer walks the model once per INIT pass.
  always_ff @(posedge clk) begin
    if (!rst_n)                 clr_ptr_q <= '0;
    else if (state_q == ST_INIT) clr_ptr_q <= clr_ptr_q + 1'b1;
  end

  // Model update: clear during INIT; in RUN, ascending channel order so the
  // highest channel writing an index leaves the final (forwarded) value.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        mem_q[clr_ptr_q] <= '0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (is_put[i]) mem_q[idx[i]] <= nxt[i];
        end
      end
    end
  end

  // Registered reporting, counters and watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      all_pass  <= 1'b1;
      err_valid <= 1'b0;
      err_code  <= 2'b00;
      err_ch    <= '0;
      err_addr  <= '0;
      err_count <= '0;
      txn_count <= '0;
      timeout   <= 1'b0;
      wd_q      <= '0;
    end else begin
      init_done <= (state_d != ST_INIT);
      err_valid <= any_err;
      txn_count <= txn_count + n_txn;
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (any_err) begin
        err_code <= sel_code;
        err_ch   <= sel_ch;
        err_addr <= sel_addr;
        all_pass <= 1'b0;
      end
      if (!timeout && !test_done) begin
        if (wd_q == WD_W'(TIMEOUT - 1)) begin
          timeout  <= 1'b1;
          all_pass <= 1'b0;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tl_scoreboard_mc.sv
// tb_tl_scoreboard_mc: directed bench for tl_scoreboard_mc.
module tb_tl_scoreboard_mc;

  localparam int NUM_CH    = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 64;
  localparam int MEM_DEPTH = 1024;
  localparam int TIMEOUT   = 10000;
  localparam int BYTES     = DATA_W / 8;

  logic                        clk;
  logic                        rst_n;
  logic [NUM_CH-1:0]           txn_valid;
  logic [2*NUM_CH-1:0]         txn_type;
  logic [ADDR_W*NUM_CH-1:0]    txn_addr;
  logic [DATA_W*NUM_CH-1:0]    txn_wdata;
  logic [BYTES*NUM_CH-1:0]     txn_mask;
  logic [DATA_W*NUM_CH-1:0]    txn_rdata;
  logic                        test_done;
  logic                        init_done;
  logic                        all_pass;
  logic                        err_valid;
  logic [1:0]                  err_code;
  logic [$clog2(NUM_CH)-1:0]   err_ch;
  logic [ADDR_W-1:0]           err_addr;
  logic [15:0]                 err_count;
  logic [31:0]                 txn_count;
  logic                        timeout;

  int checks = 0;
  int errors = 0;

  tl_scoreboard_mc #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MEM_DEPTH(MEM_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .txn_valid(txn_valid), .txn_type(txn_type),
    .txn_addr(txn_addr), .txn_wdata(txn_wdata), .txn_mask(txn_mask),
    .txn_rdata(txn_rdata), .test_done(test_done), .init_done(init_done),
    .all_pass(all_pass), .err_valid(err_valid), .err_code(err_code),
    .err_ch(err_ch), .err_addr(err_addr), .err_count(err_count),
    .txn_count(txn_count), .timeout(timeout)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs are sampled at the edge, outputs checked 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    txn_valid = '0;
    txn_type  = '0;
    txn_addr  = '0;
    txn_wdata = '0;
    txn_mask  = '0;
    txn_rdata = '0;
  endtask

  task automatic drive(input int ch, input logic [1:0] typ, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [7:0] mask,
                       input logic [63:0] rdata);
    txn_valid[ch]               = 1'b1;
    txn_type[2*ch +: 2]         = typ;
    txn_addr[ADDR_W*ch +: ADDR_W] = addr;
    txn_wdata[DATA_W*ch +: DATA_W] = wdata;
    txn_mask[BYTES*ch +: BYTES] = mask;
    txn_rdata[DATA_W*ch +: DATA_W] = rdata;
  endtask

  // Apply reset for two clocks and release it just after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    test_done = 1'b0;
    clear_in();

    // T1: reset values and init timing
    do_reset();
    check("rst_init_done", init_done, 0);
    check("rst_all_pass", all_pass, 1);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_count", err_count, 0);
    check("rst_txn_count", txn_count, 0);
    check("rst_timeout", timeout, 0);
    repeat (MEM_DEPTH - 1) step();
    check("init_done_early", init_done, 0);
    step();
    check("init_done_on_time", init_done, 1);
    drive(0, 2'b00, 32'h40, 64'h0, 8'h0, 64'h0);
    step(); clear_in();
    check("t1_get_err", err_valid, 0);
    check("t1_txn_count", txn_count, 1);

    // T2: PutFull, PutPartial, Get pass, Get mismatch
    drive(1, 2'b01, 32'h80, 64'hDEAD_BEEF_0123_4567, 8'h0, 64'h0);
    step(); clear_in();
    drive(1, 2'b10, 32'h80, 64'h0, 8'h0F, 64'h0);
    step(); clear_in();
    check("t2_puts_no_err", err_valid, 0);
    drive(1, 2'b00, 32'h80, 64'h0, 8'h0, 64'hDEAD_BEEF_0000_0000);
    step(); clear_in();
    check("t2_get_pass", err_valid, 0);
    check("t2_all_pass_hi", all_pass, 1);
    check("t2_txn_count", txn_count, 4);
    drive(1, 2'b00, 32'h80, 64'h0, 8'h0, 64'hDEAD_BEEF_0123_4567);
    step(); clear_in();
    check("t2_mm_valid", err_valid, 1);
    check("t2_mm_code", err_code, 0);
    check("t2_mm_ch", err_ch, 1);
    check("t2_mm_addr", err_addr, 32'h80);
    check("t2_mm_count", err_count, 1);
    check("t2_mm_all_pass", all_pass, 0);
    check("t2_mm_txn", txn_count, 5);
    step();
    check("t2_valid_pulse", err_valid, 0);

    // T3: same-cycle ordering between channels
    drive(0, 2'b01, 32'h100, 64'h5, 8'h0, 64'h0);
    drive(2, 2'b00, 32'h100, 64'h0, 8'h0, 64'h5);
    step(); clear_in();
    check("t3_fwd_no_err", err_valid, 0);
    check("t3_txn_count", txn_count, 7);
    drive(1, 2'b00, 32'h180, 64'h0, 8'h0, 64'h0);
    drive(3, 2'b01, 32'h180, 64'hAA, 8'h0, 64'h0);
    step(); clear_in();
    check("t3_low_get_old", err_valid, 0);
    drive(2, 2'b10, 32'h180, 64'hFF, 8'h00, 64'h0);
    drive(3, 2'b00, 32'h180, 64'h0, 8'h0, 64'hAA);
    step(); clear_in();
    check("t3_mask0_noop", err_valid, 0);
    check("t3_txn_count2", txn_count, 11);
    check("t3_err_count", err_count, 1);

    // T4: illegal type and out-of-range in one cycle, then range alone
    drive(1, 2'b11, 32'h10, 64'h0, 8'h0, 64'h0);
    drive(3, 2'b00, MEM_DEPTH * 8, 64'h0, 8'h0, 64'h0);
    step(); clear_in();
    check("t4_valid", err_valid, 1);
    check("t4_ch", err_ch, 1);
    check("t4_code", err_code, 1);
    check("t4_addr", err_addr, 32'h10);
    check("t4_count", err_count, 3);
    check("t4_txn", txn_count, 13);
    drive(2, 2'b01, MEM_DEPTH * 8, 64'h1234, 8'h0, 64'h0);
    step(); clear_in();
    check("t4_rng_code", err_code, 2);
    check("t4_rng_ch", err_ch, 2);
    check("t4_rng_addr", err_addr, MEM_DEPTH * 8);
    check("t4_rng_count", err_count, 4);
    drive(0, 2'b00, 32'h0, 64'h0, 8'h0, 64'h0);
    step(); clear_in();
    check("t4_no_wrap_write", err_valid, 0);
    drive(0, 2'b01, (MEM_DEPTH - 1) * 8, 64'h77, 8'h0, 64'h0);
    step(); clear_in();
    drive(2, 2'b00, (MEM_DEPTH - 1) * 8, 64'h0, 8'h0, 64'h77);
    step(); clear_in();
    check("t4_last_word", err_valid, 0);
    check("t4_txn2", txn_count, 17);

    // T5: reset mid-RUN, strobe during INIT, model cleared again, DONE state
    rst_n = 1'b0;
    step();
    check("t5_rst_init_done", init_done, 0);
    check("t5_rst_txn", txn_count, 0);
    check("t5_rst_errs", err_count, 0);
    check("t5_rst_all_pass", all_pass, 1);
    rst_n = 1'b1;
    drive(2, 2'b00, 32'h0, 64'h0, 8'h0, 64'h0);
    step(); clear_in();
    check("t5_init_code", err_code, 3);
    check("t5_init_ch", err_ch, 2);
    check("t5_init_valid", err_valid, 1);
    check("t5_init_txn", txn_count, 0);
    check("t5_init_count", err_count, 1);
    repeat (MEM_DEPTH - 2) step();
    check("t5_init_done_early", init_done, 0);
    step();
    check("t5_init_done", init_done, 1);
    drive(1, 2'b00, 32'h80, 64'h0, 8'h0, 64'h0);
    drive(3, 2'b00, 32'h100, 64'h0, 8'h0, 64'h0);
    step(); clear_in();
    check("t5_cleared", err_valid, 0);
    check("t5_txn", txn_count, 2);
    test_done = 1'b1;
    step();
    test_done = 1'b0;
    drive(0, 2'b00, 32'h0, 64'h0, 8'h0, 64'h0);
    step(); clear_in();
    check("t5_done_code", err_code, 3);
    check("t5_done_txn", txn_count, 2);
    check("t5_done_count", err_count, 2);

    // T6: watchdog fires at TIMEOUT, then frozen by test_done
    do_reset();
    repeat (TIMEOUT - 1) step();
    check("t6_timeout_early", timeout, 0);
    step();
    check("t6_timeout", timeout, 1);
    check("t6_all_pass", all_pass, 0);
    check("t6_err_count", err_count, 0);
    step();
    check("t6_timeout_sticky", timeout, 1);
    do_reset();
    check("t6_rst_timeout", timeout, 0);
    repeat (400) step();
    test_done = 1'b1;
    repeat (TIMEOUT + 100) step();
    check("t6_frozen", timeout, 0);
    check("t6_frozen_pass", all_pass, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
